// File: rtl/deintlv_pkg.sv
// deintlv_pkg: constants and the address permutation shared by the 8x256
// block deinterleaver. These are used by the write controller, the
// interleaver address generator and the read-side model.
//   ROWS_LOG2 / COLS_LOG2 : log2 of the row / column count (8 x 256)
//   N_LOG2 / N            : frame length as log2 (11) and as a count (2048)
//   DATA_W                : symbol width
//   perm_idx(k)           : buffer index of the k-th received symbol
package deintlv_pkg;

  localparam int ROWS_LOG2 = 3;
  localparam int COLS_LOG2 = 8;
  localparam int N_LOG2    = ROWS_LOG2 + COLS_LOG2;
  localparam int N         = 1 << N_LOG2;
  localparam int DATA_W    = 8;

  // Inverse of the column-wise interleaver write order:
  // idx = (k mod 8)*256 + (k div 8)
  function automatic logic [N_LOG2-1:0] perm_idx(input logic [N_LOG2-1:0] k);
    return {k[ROWS_LOG2-1:0], k[N_LOG2-1:ROWS_LOG2]};
  endfunction

endpackage

// File: rtl/deintlv_wr_ctrl_tgl_sync.sv
// tgl_sync: brings a toggle-encoded event into the clk domain.
// Two flops resolve metastability, a third holds the previous synchronized
// level. pulse is high for one clk cycle after each input toggle.
//   clk   in  destination clock
//   reset in  synchronous, active-high reset (all flops to 0)
//   tgl   in  toggle from the foreign clock domain
//   pulse out one-cycle event pulse (s2 ^ s3)
module tgl_sync (
  input  logic clk,
  input  logic reset,
  input  logic tgl,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tgl;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 ^ s3;

endmodule

// File: rtl/deintlv_wr_ctrl.sv
// deintlv_wr_ctrl: write side of the 8x256 ping-pong block deinterleaver.
// Accepts symbols over valid/ready and writes each one to the
// inverse-permuted address of the current bank. It signals completed banks
// to the Readclk reader and frees banks on the reader's release toggles.
//   Writeclk        in   write-domain clock
//   reset           in   synchronous, active-high reset
//   in_valid        in   input symbol valid
//   in_data         in   input symbol
//   in_ready        out  a symbol is accepted this cycle if in_valid is high
//   wr_en           out  RAM port-A write enable (registered)
//   wr_addr         out  RAM port-A address {bank, permuted index} (registered)
//   wr_data         out  RAM port-A data (registered)
//   frame_done_tgl  out  toggles once per completed bank
//   rd_release_tgl  in   toggles once per bank released by the reader (async)
//   bank_full       out  per-bank FULL status (the bank state machine)
//   release_err     out  sticky: a release arrived while no bank was FULL
//   frame_cnt       out  completed frames, wraps 65535 -> 0
//
// Handshake: a symbol transfers on any Writeclk edge where in_valid and
// in_ready are both high. in_ready depends only on registered state and
// reset, never on in_valid. The source must hold in_valid/in_data until
// the transfer happens.
module deintlv_wr_ctrl
  import deintlv_pkg::*;
#(
  parameter int ROWS_LOG2 = deintlv_pkg::ROWS_LOG2,
  parameter int COLS_LOG2 = deintlv_pkg::COLS_LOG2,
  parameter int DATA_W    = deintlv_pkg::DATA_W,
  parameter int N_LOG2    = ROWS_LOG2 + COLS_LOG2
) (
  input  logic              Writeclk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [N_LOG2:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done_tgl,
  input  logic              rd_release_tgl,
  output logic [1:0]        bank_full,
  output logic              release_err,
  output logic [15:0]       frame_cnt
);

  logic [N_LOG2-1:0] k;
  logic              wr_bank;
  logic              rd_bank;
  logic              accept;
  logic              k_last;
  logic              rel_pulse;
  logic [1:0]        bank_full_nxt;

  tgl_sync u_rel_sync (
    .clk   (Writeclk),
    .reset (reset),
    .tgl   (rd_release_tgl),
    .pulse (rel_pulse)
  );

  assign in_ready = !reset && !bank_full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign k_last   = &k;

  // Completion and release may hit in the same cycle. They never target
  // the same bank: the release only acts on a bank that was already FULL
  // before this edge, and a bank being written cannot be FULL.
  always_comb begin
    bank_full_nxt = bank_full;
    if (accept && k_last) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
    if (rel_pulse && bank_full[rd_bank]) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge Writeclk) begin
    if (reset) begin
      k              <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      bank_full      <= 2'b00;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      frame_done_tgl <= 1'b0;
      release_err    <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      wr_en     <= accept;

      if (accept) begin
        // Row-major read-back of a column-wise write: low k bits pick the row.
        wr_addr <= {wr_bank, k[ROWS_LOG2-1:0], k[N_LOG2-1:ROWS_LOG2]};
        wr_data <= in_data;
        k       <= k + 1'b1;
        if (k_last) begin
          wr_bank        <= ~wr_bank;
          frame_done_tgl <= ~frame_done_tgl;
          frame_cnt      <= frame_cnt + 16'd1;
        end
      end

      if (rel_pulse) begin
        if (bank_full[rd_bank]) begin
          rd_bank <= ~rd_bank;
        end else begin
          release_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_deintlv_wr_ctrl.sv
module tb_deintlv_wr_ctrl;

  localparam int DATA_W = 8;
  localparam int N_LOG2 = 11;
  localparam int N      = 2048;

  // ---------------- clock / reset ----------------
  logic              Writeclk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [N_LOG2:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_done_tgl;
  logic              rd_release_tgl;
  logic [1:0]        bank_full;
  logic              release_err;
  logic [15:0]       frame_cnt;

  always #5 Writeclk = ~Writeclk;

  deintlv_wr_ctrl dut (
    .Writeclk       (Writeclk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_done_tgl (frame_done_tgl),
    .rd_release_tgl (rd_release_tgl),
    .bank_full      (bank_full),
    .release_err    (release_err),
    .frame_cnt      (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame position, write bank, FIFO of FULL banks in fill order,
  // and the toggle history seen by the release synchronizer.
  int  m_k;
  int  m_wb;
  int  full_q[$];
  bit  m_tgl;
  int  m_fcnt;
  bit  m_err;
  bit  m_en;
  logic [N_LOG2:0]   m_addr;
  logic [DATA_W-1:0] m_data;
  bit  p1, p2, p3;
  bit  started = 1'b0;
  logic [N_LOG2+DATA_W:0] exp_q[$];

  function automatic bit in_full(input int b);
    foreach (full_q[i]) if (full_q[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge Writeclk) begin
    int pre_n;
    bit rdy;
    bit acc;
    bit pulse;
    if (reset) begin
      m_k = 0; m_wb = 0; full_q.delete(); m_tgl = 0; m_fcnt = 0; m_err = 0;
      m_en = 0; m_addr = '0; m_data = '0; p1 = 0; p2 = 0; p3 = 0;
      exp_q.delete();
      started = 1'b1;
    end else if (started) begin
      pre_n = full_q.size();
      rdy   = !in_full(m_wb);
      acc   = in_valid && rdy;
      pulse = p2 ^ p3;
      m_en  = acc;
      if (acc) begin
        m_addr = (N_LOG2+1)'(m_wb * N + (m_k % 8) * 256 + m_k / 8);
        m_data = in_data;
        exp_q.push_back({m_addr, m_data});
        m_k++;
        if (m_k == N) begin
          m_k = 0;
          full_q.push_back(m_wb);
          m_wb   = 1 - m_wb;
          m_tgl  = !m_tgl;
          m_fcnt = (m_fcnt + 1) % 65536;
        end
      end
      if (pulse) begin
        if (pre_n > 0) void'(full_q.pop_front());
        else m_err = 1'b1;
      end
      p3 = p2; p2 = p1; p1 = rd_release_tgl;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge Writeclk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(!reset && !in_full(m_wb)));
      chk("bank_full", 32'(bank_full), 32'({in_full(1), in_full(0)}));
      chk("wr_en", 32'(wr_en), 32'(m_en));
      chk("wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("wr_data", 32'(wr_data), 32'(m_data));
      chk("frame_done_tgl", 32'(frame_done_tgl), 32'(m_tgl));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      chk("release_err", 32'(release_err), 32'(m_err));
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
        end else begin
          chk("sb_write", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Writeclk);
    #2;
  endtask

  task automatic wr(input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(seed + i * 5);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic release_bank();
    rd_release_tgl = !rd_release_tgl;
    repeat (3) tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; rd_release_tgl = 1'b0;
    repeat (3) tick();
    chk("lit_ready_in_reset", 32'(in_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("lit_reset_wr_en", 32'(wr_en), 32'd0);
    chk("lit_reset_bank_full", 32'(bank_full), 32'd0);
    chk("lit_reset_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("lit_ready_after_reset", 32'(in_ready), 32'd1);

    // Two full frames back to back.
    for (int i = 0; i < 2 * N; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i * 7 + 1);
      tick();
      if (i == 0)    chk("lit_addr_first", 32'(wr_addr), 32'd0);
      if (i == 1)    chk("lit_addr_2nd", 32'(wr_addr), 32'd256);
      if (i == 7)    chk("lit_addr_8th", 32'(wr_addr), 32'd1792);
      if (i == 8)    chk("lit_addr_9th", 32'(wr_addr), 32'd1);
      if (i == N-1) begin
        chk("lit_addr_last", 32'(wr_addr), 32'd2047);
        chk("lit_full_after_f1", 32'(bank_full), 32'd1);
        chk("lit_tgl_after_f1", 32'(frame_done_tgl), 32'd1);
        chk("lit_cnt_after_f1", 32'(frame_cnt), 32'd1);
      end
      if (i == N)    chk("lit_addr_bank1_first", 32'(wr_addr), 32'd2048);
    end
    chk("lit_both_full", 32'(bank_full), 32'd3);
    chk("lit_ready_both_full", 32'(in_ready), 32'd0);
    chk("lit_cnt_after_f2", 32'(frame_cnt), 32'd2);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      tick();
      chk("lit_no_write_when_full", 32'(wr_en), 32'd0);
    end
    in_valid = 1'b0;

    // Release bank 0 while both are full.
    rd_release_tgl = 1'b1;
    tick(); tick();
    chk("lit_full_before_release", 32'(bank_full), 32'd3);
    tick();
    chk("lit_full_after_release", 32'(bank_full), 32'd2);
    chk("lit_ready_after_release", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("lit_addr_after_release", 32'(wr_addr), 32'd0);
    chk("lit_data_after_release", 32'(wr_data), 32'hA5);

    // Release bank 1, finish bank 0, then complete bank 1 on the same edge
    // that releases bank 0.
    release_bank();
    chk("lit_full_none", 32'(bank_full), 32'd0);
    wr(N - 1, 3);
    chk("lit_full_b0", 32'(bank_full), 32'd1);
    wr(N - 1, 9);
    rd_release_tgl = !rd_release_tgl;
    tick(); tick();
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    chk("lit_swap_full", 32'(bank_full), 32'd2);
    chk("lit_swap_addr", 32'(wr_addr), 32'hFFF);
    chk("lit_swap_cnt", 32'(frame_cnt), 32'd4);

    // Release with nothing FULL sets the sticky error and leaves rd_bank.
    release_bank();
    chk("lit_full_none2", 32'(bank_full), 32'd0);
    release_bank();
    chk("lit_release_err", 32'(release_err), 32'd1);
    chk("lit_full_after_err", 32'(bank_full), 32'd0);
    wr(N, 11);
    chk("lit_full_b0_again", 32'(bank_full), 32'd1);
    chk("lit_cnt5", 32'(frame_cnt), 32'd5);
    release_bank();
    chk("lit_rd_bank_kept", 32'(bank_full), 32'd0);
    chk("lit_err_sticky", 32'(release_err), 32'd1);

    // Reset in the middle of a frame.
    wr(1000, 21);
    reset = 1'b1; rd_release_tgl = 1'b0;
    tick();
    chk("lit_mid_reset_wr_en", 32'(wr_en), 32'd0);
    chk("lit_mid_reset_full", 32'(bank_full), 32'd0);
    chk("lit_mid_reset_tgl", 32'(frame_done_tgl), 32'd0);
    chk("lit_mid_reset_cnt", 32'(frame_cnt), 32'd0);
    chk("lit_mid_reset_err", 32'(release_err), 32'd0);
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    chk("lit_post_reset_en", 32'(wr_en), 32'd1);
    chk("lit_post_reset_addr", 32'(wr_addr), 32'd0);
    wr(20, 40);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deintlv_wr_ctrl.md
Name: deintlv_wr_ctrl

Overview:
Write-side controller for the 8x256 block deinterleaver buffer. The interleaver address generator writes each 2048-symbol frame column-wise, so that address = (k mod 256)*8 + (k div 256). This block is the inverse end of that link. It accepts received symbols over a valid/ready handshake and writes them at the inverse-permuted address into a ping-pong dual-port RAM (2 banks x 2048). It signals completed banks to the Readclk-domain reader and takes bank releases back from it.

Parameters:
ROWS_LOG2, 3, log2 of row count (8 rows)
COLS_LOG2, 8, log2 of column count (256 columns)
DATA_W, 8, symbol width
Derived: N_LOG2 = ROWS_LOG2+COLS_LOG2 (11); frame length N = 2^N_LOG2 (2048).

Ports:
Writeclk  in  1  write-domain clock
reset  in  1  synchronous, active-high reset; clock Writeclk
in_valid  in  1  input symbol valid
in_data  in  DATA_W  input symbol
in_ready  out  1  block can accept a symbol this cycle
wr_en  out  1  RAM port-A write enable (registered)
wr_addr  out  N_LOG2+1  RAM port-A address {bank, permuted index} (registered)
wr_data  out  DATA_W  RAM port-A data (registered)
frame_done_tgl  out  1  toggles once per completed bank (to Readclk domain)
rd_release_tgl  in  1  toggles once per bank released by reader (from Readclk domain, async)
bank_full  out  2  per-bank FULL status
release_err  out  1  sticky: release received while no bank FULL
frame_cnt  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset values (applied at the Writeclk edge with reset=1): k=0, wr_bank=0, rd_bank=0, bank_full=2'b00, wr_en=0, wr_addr=0, wr_data=0, frame_done_tgl=0, release_err=0, frame_cnt=0, release synchronizer flops=0.
- in_ready = !reset && !bank_full[wr_bank]. This is combinational from registered state, not from in_valid.
- accept = in_valid && in_ready.
- Address permutation: idx = {k[ROWS_LOG2-1:0], k[N_LOG2-1:ROWS_LOG2]}, i.e. (k mod 8)*256 + (k div 8).
  - Sequence of idx: 0,256,...,1792,1,257,...,2047.
- Latency is 1 cycle. At the edge where accept=1: wr_en<=1, wr_addr<={wr_bank, idx}, wr_data<=in_data. Otherwise wr_en<=0 and addr/data hold.
- k increments by 1 on each accept and wraps 2047->0.
- Bank completion: on the accept with k==N-1:
  - bank_full[wr_bank]<=1, wr_bank<=~wr_bank, frame_done_tgl<=~frame_done_tgl, frame_cnt<=frame_cnt+1.
  - All of these update on the same edge that registers the last write.
- Release path:
  - rd_release_tgl passes through a 2-flop synchronizer plus a third flop for edge detect; rel_pulse = s2 ^ s3.
  - On rel_pulse: if bank_full[rd_bank], then bank_full[rd_bank]<=0 and rd_bank<=~rd_bank. Otherwise release_err<=1 and nothing else changes.
- Bank states per bank: FREE (bank_full=0) -> FULL on completion -> FREE on release. Banks are read in the same order they were filled.
- Simultaneous completion and release in the same cycle: both apply.
  - If rd_bank==wr_bank-side target, the release acts on the pre-edge bank_full, so a bank completing this cycle cannot be released this cycle.
- Both banks FULL: in_ready=0. in_valid is ignored and k holds.
- Reset mid-frame: the partial frame is discarded. The reader must be reset in the same system reset window, because the toggle lines restart at 0.

Decomposition:
- Shared package deintlv_pkg holds ROWS_LOG2, COLS_LOG2, N_LOG2 and the permutation function perm_idx(k), shared with the interleaver address generator and the read-side bench model.
- One sub-module: tgl_sync (3-flop synchronizer + edge pulse). It is reused by the Readclk-side reader for frame_done_tgl.

Test Plan:
- Reset, then 2048 back-to-back accepts -> wr_addr sequence 0,256,512,...,1792,1,257,...,2047 (bank 0). bank_full=2'b01 after the 2048th write; frame_done_tgl=1; frame_cnt=1; next write goes to 2048 (bank 1, idx 0).
- Fill both banks with no release -> in_ready=0 after the 4096th accept. Further in_valid causes no wr_en and k stays 0.
- With both banks full, toggle rd_release_tgl -> 3 cycles later bank_full=2'b10 and in_ready=1. The next accept writes wr_addr=0 (bank 0).
- Toggle rd_release_tgl with bank_full=2'b00 -> release_err=1 (sticky), rd_bank unchanged.
- Release pulse lands on the same edge as bank 1 completion while bank 0 is FULL -> bank_full goes 2'b01 -> 2'b10 in one edge, rd_bank=1.
- Assert reset after 1000 accepts -> next cycle k=0, bank_full=0, wr_en=0, toggles=0. The first post-reset accept writes addr 0.
